cpu_apb_bridge: RTL and testbench

Parametrised APB master bridge between the single-cycle RISC-V core and NUM_SLAVES peripherals. It decodes core lw/sw addresses against the peripheral window and drives cancel_data_memory and stop into the core. It runs an APB SETUP/ACCESS transfer with wait-state support, slave-error capture and timeout abort. It returns read data for register writeback. It replaces per-peripheral hand wiring of stop/cancel with one generic block.

---
 rtl/cpu_apb_bridge.sv | 134 +++++++++++++
 tb/tb_cpu_apb_bridge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_apb_bridge.sv
// APB master bridge for the single-cycle RISC-V core: decodes the peripheral window,
// stalls the core for the whole SETUP/ACCESS transfer and returns read data on completion.
module cpu_apb_bridge #(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 32,
  parameter int                NUM_SLAVES    = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 'h4000_0000,
  parameter int                SLV_SIZE_LOG2 = 12,
  parameter int                TIMEOUT       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic                         cancel_data_memory,
  output logic                         stop,
  output logic [DATA_W-1:0]            rdata,
  output logic                         rdata_valid,
  output logic                         err,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  output logic                         PWRITE,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state, next_state;
  logic              req, hit;
  logic [ADDR_W-1:0] offset, slot;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              sel_ready, sel_err;
  logic [DATA_W-1:0] sel_rdata;

  // Slot index computed from the offset so a window ending at the top of the
  // address space cannot wrap the upper bound comparison.
  assign req    = mem_read | mem_write;
  assign offset = addr - BASE_ADDR;
  assign slot   = offset >> SLV_SIZE_LOG2;
  assign hit    = req && (addr >= BASE_ADDR) && (slot < ADDR_W'(NUM_SLAVES));

  assign cancel_data_memory = hit && rst;

  assign sel_ready = PREADY[idx_q];
  assign sel_err   = PSLVERR[idx_q];
  assign sel_rdata = PRDATA[idx_q*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    stop        = 1'b0;
    PSEL        = '0;
    PENABLE     = 1'b0;
    rdata_valid = 1'b0;
    case (state)
      IDLE: begin
        if (hit && rst) begin
          stop       = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: begin
        PSEL[idx_q] = 1'b1;
        stop        = 1'b1;
        next_state  = ACCESS;
      end
      ACCESS: begin
        PSEL[idx_q] = 1'b1;
        PENABLE     = 1'b1;
        stop        = 1'b1;
        if (sel_ready || (wait_cnt == CNT_LAST)) next_state = DONE;
      end
      DONE: begin
        // stop drops here so the core retires the instruction on this edge
        rdata_valid = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture in IDLE keeps PADDR/PWDATA/PWRITE stable for the whole transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PADDR    <= '0;
      PWDATA   <= '0;
      PWRITE   <= 1'b0;
      idx_q    <= '0;
      wait_cnt <= '0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            PADDR  <= {addr[ADDR_W-1:2], 2'b00};
            PWDATA <= wdata;
            PWRITE <= mem_write;
            idx_q  <= slot[IDX_W-1:0];
          end
        end
        SETUP: wait_cnt <= '0;
        ACCESS: begin
          if (sel_ready) begin
            rdata <= PWRITE ? '0 : sel_rdata;
            err   <= sel_err;
          end else if (wait_cnt == CNT_LAST) begin
            rdata <= '0;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_apb_bridge.sv
// Directed bench for cpu_apb_bridge: the bench plays the APB slaves and the core,
// checking latency, bus signalling, error/timeout capture and reset behaviour.
module tb_cpu_apb_bridge;

  logic         clk, rst;
  logic         mem_read, mem_write;
  logic [31:0]  addr, wdata;
  logic         cancel_data_memory, stop, rdata_valid, err;
  logic [31:0]  rdata, PADDR, PWDATA;
  logic         PWRITE, PENABLE;
  logic [3:0]   PSEL, PREADY, PSLVERR;
  logic [127:0] PRDATA;

  int checks = 0;
  int failures = 0;

  int          stop_cycles;
  logic [3:0]  psel_seen;
  logic [31:0] paddr_seen, pwdata_seen;
  logic        pwrite_seen;

  cpu_apb_bridge dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
    .cancel_data_memory(cancel_data_memory), .stop(stop),
    .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    #1;
  endtask

  // Plays the selected slave: PREADY held low for the first 'waits' ACCESS cycles.
  task automatic runTransfer(input int waits);
    int acc;
    acc         = 0;
    stop_cycles = 0;
    psel_seen   = '0;
    paddr_seen  = '0;
    pwdata_seen = '0;
    pwrite_seen = 1'b0;
    while (stop && stop_cycles < 200) begin
      psel_seen = psel_seen | PSEL;
      if (PENABLE) begin
        paddr_seen  = PADDR;
        pwdata_seen = PWDATA;
        pwrite_seen = PWRITE;
        PREADY      = (acc >= waits) ? 4'b1111 : 4'b0000;
        acc++;
      end else begin
        PREADY = 4'b1111;
      end
      stop_cycles++;
      tick();
    end
    PREADY = 4'b1111;
  endtask

  task automatic finishTransfer;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("after_done_valid", rdata_valid, 0);
  endtask

  initial begin
    rst       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    PRDATA    = {32'h1234_5678, 32'hAAAA_0002, 32'h1111_0001, 32'hBBBB_0000};
    PREADY    = 4'b1111;
    PSLVERR   = 4'b0000;
    #1;
    checkOutput("rst_stop", stop, 0);
    checkOutput("rst_psel", PSEL, 0);
    checkOutput("rst_penable", PENABLE, 0);
    checkOutput("rst_pwrite", PWRITE, 0);
    checkOutput("rst_paddr", PADDR, 0);
    checkOutput("rst_pwdata", PWDATA, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_valid", rdata_valid, 0);
    checkOutput("rst_err", err, 0);
    applyStimulus(1'b1, 1'b0, 32'h4000_0000, 32'h0);
    checkOutput("rst_cancel_forced", cancel_data_memory, 0);
    checkOutput("rst_stop_forced", stop, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // read from slave 3 with two wait states
    applyStimulus(1'b1, 1'b0, 32'h4000_3000, 32'h0);
    checkOutput("rd_cancel", cancel_data_memory, 1);
    checkOutput("rd_stop_req", stop, 1);
    runTransfer(2);
    checkOutput("rd_stop_cycles", stop_cycles, 5);
    checkOutput("rd_psel", psel_seen, 4'b1000);
    checkOutput("rd_paddr", paddr_seen, 32'h4000_3000);
    checkOutput("rd_pwrite", pwrite_seen, 0);
    checkOutput("rd_valid", rdata_valid, 1);
    checkOutput("rd_rdata", rdata, 32'h1234_5678);
    checkOutput("rd_err", err, 0);
    finishTransfer();

    // zero-wait write to slave 1, decoy errors on unselected slaves
    PSLVERR = 4'b1101;
    applyStimulus(1'b0, 1'b1, 32'h4000_1004, 32'hDEAD_BEEF);
    runTransfer(0);
    checkOutput("wr_stop_cycles", stop_cycles, 3);
    checkOutput("wr_psel", psel_seen, 4'b0010);
    checkOutput("wr_paddr", paddr_seen, 32'h4000_1004);
    checkOutput("wr_pwdata", pwdata_seen, 32'hDEAD_BEEF);
    checkOutput("wr_pwrite", pwrite_seen, 1);
    checkOutput("wr_valid", rdata_valid, 1);
    checkOutput("wr_err", err, 0);
    checkOutput("wr_rdata", rdata, 0);
    checkOutput("wr_cancel_done", cancel_data_memory, 1);
    PSLVERR = 4'b0000;
    finishTransfer();

    // top word of the window, read+write together behaves as a write
    applyStimulus(1'b1, 1'b1, 32'h4000_3FFC, 32'h55AA_55AA);
    runTransfer(0);
    checkOutput("top_psel", psel_seen, 4'b1000);
    checkOutput("top_paddr", paddr_seen, 32'h4000_3FFC);
    checkOutput("top_pwrite", pwrite_seen, 1);
    checkOutput("top_rdata", rdata, 0);
    checkOutput("top_valid", rdata_valid, 1);
    finishTransfer();

    // slave error on slave 0
    PSLVERR = 4'b0001;
    applyStimulus(1'b1, 1'b0, 32'h4000_0000, 32'h0);
    runTransfer(0);
    checkOutput("serr_stop_cycles", stop_cycles, 3);
    checkOutput("serr_psel", psel_seen, 4'b0001);
    checkOutput("serr_err", err, 1);
    checkOutput("serr_rdata", rdata, 32'hBBBB_0000);
    checkOutput("serr_valid", rdata_valid, 1);
    PSLVERR = 4'b0000;
    finishTransfer();

    // timeout on slave 2, unaligned address gets word-aligned
    applyStimulus(1'b1, 1'b0, 32'h4000_2003, 32'h0);
    runTransfer(1000);
    checkOutput("tmo_stop_cycles", stop_cycles, 18);
    checkOutput("tmo_psel", psel_seen, 4'b0100);
    checkOutput("tmo_paddr", paddr_seen, 32'h4000_2000);
    checkOutput("tmo_err", err, 1);
    checkOutput("tmo_rdata", rdata, 0);
    checkOutput("tmo_valid", rdata_valid, 1);
    finishTransfer();

    // addresses outside the window
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    checkOutput("np_cancel", cancel_data_memory, 0);
    checkOutput("np_stop", stop, 0);
    tick();
    checkOutput("np_psel", PSEL, 0);
    checkOutput("np_penable", PENABLE, 0);
    applyStimulus(1'b1, 1'b0, 32'h4000_4000, 32'h0);
    checkOutput("above_cancel", cancel_data_memory, 0);
    checkOutput("above_stop", stop, 0);
    tick();
    checkOutput("above_psel", PSEL, 0);
    applyStimulus(1'b0, 1'b1, 32'h3FFF_FFFC, 32'h0);
    checkOutput("below_cancel", cancel_data_memory, 0);
    tick();
    checkOutput("below_valid", rdata_valid, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    // reset in the middle of ACCESS
    PREADY = 4'b0000;
    applyStimulus(1'b0, 1'b1, 32'h4000_1000, 32'h0BAD_F00D);
    tick();
    tick();
    checkOutput("mid_penable", PENABLE, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_psel", PSEL, 0);
    checkOutput("mid_rst_penable", PENABLE, 0);
    checkOutput("mid_rst_stop", stop, 0);
    checkOutput("mid_rst_valid", rdata_valid, 0);
    checkOutput("mid_rst_cancel", cancel_data_memory, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    PREADY = 4'b1111;
    tick();
    rst = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b1, 32'h4000_0008, 32'hCAFE_F00D);
    runTransfer(0);
    checkOutput("post_rst_stop_cycles", stop_cycles, 3);
    checkOutput("post_rst_paddr", paddr_seen, 32'h4000_0008);
    checkOutput("post_rst_pwdata", pwdata_seen, 32'hCAFE_F00D);
    checkOutput("post_rst_valid", rdata_valid, 1);
    checkOutput("post_rst_err", err, 0);
    finishTransfer();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
